// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
// funct3 encodings, FSM state type and the store byte-lane helper.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   // Byte enable for a store of the given size at byte offset addr.
   function automatic logic [3:0] lane_strb(
      input logic [2:0] funct3,
      input logic [1:0] addr
   );
      logic [3:0] s;
      s = '0;
      case (funct3[1:0])
         2'b00:   s = 4'b0001 << addr;
         2'b01:   s = 4'b0011 << {addr[1], 1'b0};
         2'b10:   s = 4'b1111;
         default: s = '0;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous word RAM with per-byte write enables.
// Ports: clk_i, en_i, we_i[3:0], addr_i, wdata_i -> rdata_o (registered).
module dmem_array #(
   parameter int DEPTH_WORDS = 1024,
   parameter int AW          = 10
) (
   input  logic          clk_i,
   input  logic          en_i,
   input  logic [3:0]    we_i,
   input  logic [AW-1:0] addr_i,
   input  logic [31:0]   wdata_i,
   output logic [31:0]   rdata_o
);

   logic [31:0] mem_q [DEPTH_WORDS];
   logic [31:0] rdata_q;

   // Contents survive reset, so no reset branch here.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (|we_i) begin
            for (int i = 0; i < 4; i++) begin
               if (we_i[i]) begin
                  mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
               end
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder: handshake, fixed latency, byte lanes, load extend.
// Ports: clk, rst_n, req_* (valid/ready request), resp_* (one-cycle result).
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
   localparam logic [29:0] DEPTH_L  = 30'(DEPTH_WORDS);
   localparam bit DIRECT = (LATENCY == 1);

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        err_q, err_d;
   logic        write_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;

   logic        accept;
   logic        commit;
   logic        c_write;
   logic [2:0]  c_f3;
   logic [31:0] c_addr;
   logic [31:0] c_wdata;
   logic        c_err;

   logic        mem_en;
   logic [3:0]  mem_we;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic [31:0] shifted;
   logic [31:0] load_val;

   function automatic logic req_bad(
      input logic        wr,
      input logic [2:0]  f3,
      input logic [31:0] a
   );
      logic legal;
      logic mis;
      logic oor;
      legal = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
      if (!wr) begin
         legal = legal || (f3 == F3_BU) || (f3 == F3_HU);
      end
      mis = ((f3[1:0] == 2'b01) && a[0])
         || ((f3[1:0] == 2'b10) && (a[1:0] != 2'b00));
      oor = (a[31:2] >= DEPTH_L);
      return !legal || mis || oor;
   endfunction

   assign accept = req_valid && req_ready;

   // With LATENCY 1 the commit edge is the acceptance edge itself,
   // so the array must see the live request instead of the latch.
   always_comb begin
      if (DIRECT) begin
         c_write = req_write;
         c_f3    = req_funct3;
         c_addr  = req_addr;
         c_wdata = req_wdata;
      end else begin
         c_write = write_q;
         c_f3    = f3_q;
         c_addr  = addr_q;
         c_wdata = wdata_q;
      end
      c_err = req_bad(c_write, c_f3, c_addr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
         write_q <= 1'b0;
         f3_q    <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         if (accept) begin
            write_q <= req_write;
            f3_q    <= req_funct3;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      commit  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (accept) begin
               if (DIRECT) begin
                  state_d = RESP;
                  commit  = 1'b1;
               end else begin
                  state_d = BUSY;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         BUSY: begin
            if (cnt_q == 4'd0) begin
               state_d = RESP;
               commit  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: begin
            state_d = IDLE;
            err_d   = 1'b0;
         end
         default: state_d = IDLE;
      endcase
      if (commit) begin
         err_d = c_err;
      end
   end

   // Store data is replicated across lanes; the strobe picks the lane.
   always_comb begin
      mem_en = commit && !c_err;
      mem_we = c_write ? lane_strb(c_f3, c_addr[1:0]) : 4'b0000;
      unique case (c_f3[1:0])
         2'b00:   mem_wdata = {4{c_wdata[7:0]}};
         2'b01:   mem_wdata = {2{c_wdata[15:0]}};
         default: mem_wdata = c_wdata;
      endcase
   end

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS),
      .AW          (AW)
   ) u_array (
      .clk_i   (clk),
      .en_i    (mem_en),
      .we_i    (mem_we),
      .addr_i  (c_addr[AW+1:2]),
      .wdata_i (mem_wdata),
      .rdata_o (mem_rdata)
   );

   always_comb begin
      shifted = mem_rdata >> {addr_q[1:0], 3'b000};
      unique case (f3_q)
         F3_B:    load_val = {{24{shifted[7]}}, shifted[7:0]};
         F3_H:    load_val = {{16{shifted[15]}}, shifted[15:0]};
         F3_W:    load_val = mem_rdata;
         F3_BU:   load_val = {24'd0, shifted[7:0]};
         F3_HU:   load_val = {16'd0, shifted[15:0]};
         default: load_val = '0;
      endcase
   end

   always_comb begin
      req_ready  = rst_n && (state_q == IDLE);
      resp_valid = (state_q == RESP);
      resp_err   = err_q;
      resp_rdata = '0;
      if ((state_q == RESP) && !err_q && !write_q) begin
         resp_rdata = load_val;
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder against a byte-array model.
// Directed scenarios plus randomized loads/stores.
module tb_dmem_responder;

   localparam int L     = 2;
   localparam int DEPTH = 1024;

   typedef struct {
      bit          w;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [31:0] d;
   } op_t;

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;

   int n_chk;
   int n_fail;

   logic [7:0] mdl [0:4*DEPTH-1];

   dmem_responder #(
      .DEPTH_WORDS (DEPTH),
      .LATENCY     (L)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic op_t mk(bit w, logic [2:0] f3,
                              logic [31:0] a, logic [31:0] d);
      op_t o;
      o.w  = w;
      o.f3 = f3;
      o.a  = a;
      o.d  = d;
      return o;
   endfunction

   // Reference: access size from funct3, bytes little-endian.
   function automatic void model_access(
      input bit w, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] wd,
      output logic [31:0] rd, output logic er);
      int n;
      logic [31:0] v;
      rd = '0;
      case (f3)
         3'd0:    n = 1;
         3'd1:    n = 2;
         3'd2:    n = 4;
         3'd4:    n = w ? 0 : 1;
         3'd5:    n = w ? 0 : 2;
         default: n = 0;
      endcase
      if (n == 0) er = 1'b1;
      else er = ((a % n) != 0) || ((a / 4) >= 32'(DEPTH));
      if (er) return;
      if (w) begin
         for (int i = 0; i < n; i++) mdl[a + i] = wd[8*i +: 8];
      end else begin
         v = '0;
         for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[a + i];
         if (!f3[2] && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
         rd = v;
      end
   endfunction

   // Drives one request; returns what the DUT produced.
   task automatic do_req(
      input bit w, input logic [2:0] f3,
      input logic [31:0] a, input logic [31:0] wd,
      output logic [31:0] rd, output logic er,
      output int lat, output bit pok);
      int k;
      pok = 1'b1;
      lat = -1;
      rd  = '0;
      er  = 1'b0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = w;
      req_funct3 = f3;
      req_addr   = a;
      req_wdata  = wd;
      k = 0;
      while (!req_ready && k < 50) begin
         @(negedge clk);
         k++;
      end
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      k = 1;
      while (!resp_valid && k < 50) begin
         if (req_ready) pok = 1'b0;
         @(negedge clk);
         k++;
      end
      if (resp_valid) begin
         lat = k - 1;
         rd  = resp_rdata;
         er  = resp_err;
         if (req_ready) pok = 1'b0;
         @(negedge clk);
         if (resp_valid || resp_rdata != 0 || resp_err || !req_ready)
            pok = 1'b0;
      end
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_funct3 = '0;
      req_addr  = '0;
      req_wdata = '0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ready got %b exp 0", req_ready);
      end
      n_chk++;
      if ({resp_valid, resp_err, resp_rdata} !== 34'd0) begin
         n_fail++;
         $display("FAIL reset_resp got v=%b e=%b d=%h exp 0",
                  resp_valid, resp_err, resp_rdata);
      end
      rst_n = 1'b1;
      @(negedge clk);
      n_chk++;
      if (req_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL idle_ready got %b exp 1", req_ready);
      end
   endtask

   task automatic test_word_round_trip();
      op_t ops[$];
      logic [31:0] rd, erd;
      logic er, eer;
      int lat;
      bit pok;
      ops.push_back(mk(1, 3'b010, 32'h10, 32'hDEAD_BEEF));
      ops.push_back(mk(0, 3'b010, 32'h10, 32'h0));
      foreach (ops[i]) begin
         do_req(ops[i].w, ops[i].f3, ops[i].a, ops[i].d, rd, er, lat, pok);
         model_access(ops[i].w, ops[i].f3, ops[i].a, ops[i].d, erd, eer);
         n_chk++;
         if (rd !== erd || er !== eer) begin
            n_fail++;
            $display("FAIL word_rt a=%h got %h/%b exp %h/%b",
                     ops[i].a, rd, er, erd, eer);
         end
         n_chk++;
         if (lat != L) begin
            n_fail++;
            $display("FAIL word_lat got %0d exp %0d", lat, L);
         end
      end
   endtask

   task automatic test_subword();
      op_t ops[$];
      logic [31:0] rd, erd;
      logic er, eer;
      int lat;
      bit pok;
      ops.push_back(mk(1, 3'b010, 32'h10, 32'h0));
      ops.push_back(mk(1, 3'b000, 32'h11, 32'h80));
      ops.push_back(mk(0, 3'b010, 32'h10, 32'h0));
      ops.push_back(mk(0, 3'b000, 32'h11, 32'h0));
      ops.push_back(mk(0, 3'b100, 32'h11, 32'h0));
      ops.push_back(mk(1, 3'b001, 32'h12, 32'h1234));
      ops.push_back(mk(0, 3'b101, 32'h12, 32'h0));
      ops.push_back(mk(0, 3'b001, 32'h10, 32'h0));
      ops.push_back(mk(0, 3'b010, 32'h10, 32'h0));
      foreach (ops[i]) begin
         do_req(ops[i].w, ops[i].f3, ops[i].a, ops[i].d, rd, er, lat, pok);
         model_access(ops[i].w, ops[i].f3, ops[i].a, ops[i].d, erd, eer);
         n_chk++;
         if (rd !== erd || er !== eer) begin
            n_fail++;
            $display("FAIL subword f3=%b a=%h got %h/%b exp %h/%b",
                     ops[i].f3, ops[i].a, rd, er, erd, eer);
         end
         n_chk++;
         if (lat != L || !pok) begin
            n_fail++;
            $display("FAIL subword_timing lat %0d exp %0d post %b",
                     lat, L, pok);
         end
      end
   endtask

   task automatic test_errors();
      op_t ops[$];
      logic [31:0] rd, erd;
      logic er, eer;
      int lat;
      bit pok;
      ops.push_back(mk(1, 3'b010, 32'h14, 32'h0BAD_F00D));
      ops.push_back(mk(0, 3'b010, 32'h13, 32'h0));
      ops.push_back(mk(1, 3'b001, 32'h15, 32'hFFFF));
      ops.push_back(mk(0, 3'b010, 32'h14, 32'h0));
      ops.push_back(mk(0, 3'b011, 32'h14, 32'h0));
      ops.push_back(mk(1, 3'b100, 32'h14, 32'h55));
      ops.push_back(mk(0, 3'b010, 32'h14, 32'h0));
      ops.push_back(mk(0, 3'b010, 32'h1000, 32'h0));
      ops.push_back(mk(1, 3'b000, 32'h1000, 32'h77));
      ops.push_back(mk(1, 3'b010, 32'hFFC, 32'h1357_9BDF));
      ops.push_back(mk(0, 3'b101, 32'hFFE, 32'h0));
      ops.push_back(mk(0, 3'b000, 32'hFFF, 32'h0));
      foreach (ops[i]) begin
         do_req(ops[i].w, ops[i].f3, ops[i].a, ops[i].d, rd, er, lat, pok);
         model_access(ops[i].w, ops[i].f3, ops[i].a, ops[i].d, erd, eer);
         n_chk++;
         if (rd !== erd || er !== eer) begin
            n_fail++;
            $display("FAIL err_case f3=%b a=%h got %h/%b exp %h/%b",
                     ops[i].f3, ops[i].a, rd, er, erd, eer);
         end
         n_chk++;
         if (lat != L || !pok) begin
            n_fail++;
            $display("FAIL err_timing lat %0d exp %0d post %b", lat, L, pok);
         end
      end
   endtask

   task automatic test_random();
      logic [31:0] rd, erd, a, d;
      logic [2:0] f3;
      logic er, eer;
      bit w;
      int lat;
      bit pok;
      for (int i = 0; i < 16; i++) begin
         d = $urandom;
         do_req(1, 3'b010, 32'(4*i), d, rd, er, lat, pok);
         model_access(1, 3'b010, 32'(4*i), d, erd, eer);
      end
      for (int i = 0; i < 60; i++) begin
         w  = 1'($urandom_range(0, 1));
         f3 = 3'($urandom_range(0, 7));
         d  = $urandom;
         if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 15);
         else a = $urandom_range(0, 63);
         do_req(w, f3, a, d, rd, er, lat, pok);
         model_access(w, f3, a, d, erd, eer);
         n_chk++;
         if (rd !== erd || er !== eer) begin
            n_fail++;
            $display("FAIL random w=%b f3=%b a=%h got %h/%b exp %h/%b",
                     w, f3, a, rd, er, erd, eer);
         end
         n_chk++;
         if (lat != L || !pok) begin
            n_fail++;
            $display("FAIL random_timing lat %0d exp %0d post %b",
                     lat, L, pok);
         end
      end
   endtask

   // One request spends an IDLE cycle, L BUSY cycles and a RESP cycle.
   task automatic test_back_to_back();
      int acc, pulses, exp_acc, win;
      bit prev, dbl, overlap;
      win = 8;
      exp_acc = (win + L + 1) / (L + 2);
      acc = 0;
      pulses = 0;
      prev = 1'b0;
      dbl = 1'b0;
      overlap = 1'b0;
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h10;
      for (int c = 0; c < win + 12; c++) begin
         if (c == win) req_valid = 1'b0;
         if (req_valid && req_ready) acc++;
         if (resp_valid) pulses++;
         if (resp_valid && prev) dbl = 1'b1;
         if (resp_valid && req_ready) overlap = 1'b1;
         prev = resp_valid;
         @(negedge clk);
      end
      n_chk++;
      if (acc != exp_acc) begin
         n_fail++;
         $display("FAIL b2b_accepts got %0d exp %0d", acc, exp_acc);
      end
      n_chk++;
      if (pulses != exp_acc) begin
         n_fail++;
         $display("FAIL b2b_pulses got %0d exp %0d", pulses, exp_acc);
      end
      n_chk++;
      if (dbl || overlap) begin
         n_fail++;
         $display("FAIL b2b_shape wide=%b ready_in_resp=%b exp 0/0",
                  dbl, overlap);
      end
   endtask

   task automatic test_reset_mid();
      logic [31:0] rd, erd;
      logic er, eer;
      int lat;
      bit pok, seen, rdy_bad;
      do_req(1, 3'b010, 32'h20, 32'h1122_3344, rd, er, lat, pok);
      model_access(1, 3'b010, 32'h20, 32'h1122_3344, erd, eer);
      @(negedge clk);
      req_valid  = 1'b1;
      req_write  = 1'b1;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      req_wdata  = 32'hA5A5_A5A5;
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      seen = 1'b0;
      rdy_bad = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
         if (req_ready) rdy_bad = 1'b1;
      end
      rst_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (resp_valid) seen = 1'b1;
         if (!req_ready) rdy_bad = 1'b1;
      end
      n_chk++;
      if (seen) begin
         n_fail++;
         $display("FAIL abort_resp got resp_valid 1 exp 0");
      end
      n_chk++;
      if (rdy_bad) begin
         n_fail++;
         $display("FAIL abort_ready got wrong ready around reset exp 0 then 1");
      end
      do_req(0, 3'b010, 32'h20, 32'h0, rd, er, lat, pok);
      model_access(0, 3'b010, 32'h20, 32'h0, erd, eer);
      n_chk++;
      if (rd !== erd || er !== eer) begin
         n_fail++;
         $display("FAIL abort_data got %h/%b exp %h/%b", rd, er, erd, eer);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk  = 0;
      n_fail = 0;
      test_reset();
      test_word_round_trip();
      test_subword();
      test_errors();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
